zba_reg_checker: RTL

- Hardware self-check engine for the RV64 Zba core. Generalises the fixed bench-side register check into a parametrised, synthesizable block.
- Holds a programmable table of (register index, expected value) pairs and waits a programmable settle time after start.
- Then walks the table through a register-file read port, compares each entry, and reports pass/fail, error count and first failure.
- Sits beside risc_top; it is the register file's second read port.

---
 rtl/zba_reg_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/zba_reg_checker.sv
// Register-file self-check: after a settle delay, walks a table of (reg, value) pairs through a read port and reports pass/fail.
// Latency: settle + 2 cycles per valid entry + 1 per invalid entry + 1 to DONE; no backpressure, rf_rdata is taken one cycle after rf_raddr.
module zba_reg_checker #(
    parameter int XLEN    = 64,
    parameter int NREGS   = 32,
    parameter int NCHECKS = 8,
    parameter int SETTLE  = 200,
    parameter int CW      = 16,
    localparam int AW     = $clog2(NREGS),
    localparam int IW     = $clog2(NCHECKS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tbl_we,
    input  logic [IW-1:0]   tbl_idx,
    input  logic [AW-1:0]   tbl_reg,
    input  logic [XLEN-1:0] tbl_val,
    input  logic            tbl_clr,
    input  logic            start,
    input  logic            stop_on_fail,
    input  logic [CW-1:0]   settle_override,
    output logic [AW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IW:0]     err_count,
    output logic [IW-1:0]   fail_idx,
    output logic [XLEN-1:0] fail_actual
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_RD     = 3'd2;
    localparam logic [2:0] S_CMP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [IW:0]   NCHK     = (IW+1)'(NCHECKS);
    localparam logic [IW:0]   ERR_MAX  = '1;
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

    logic [2:0]         state;
    logic [IW:0]        idx;
    logic [CW-1:0]      cnt;
    logic               sof;
    logic               checked;
    logic [NCHECKS-1:0] valid;
    logic [AW-1:0]      tbl_reg_q [NCHECKS];
    logic [XLEN-1:0]    tbl_val_q [NCHECKS];

    logic            idle_like;
    logic [IW-1:0]   cur;
    logic [IW:0]     idx_inc;
    logic [IW-1:0]   inc_lo;
    logic            inc_end;
    logic            mismatch;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign cur       = idx[IW-1:0];
    assign idx_inc   = idx + 1'b1;
    assign inc_lo    = idx_inc[IW-1:0];
    assign inc_end   = (idx_inc == NCHK);
    assign mismatch  = (rf_rdata != tbl_val_q[cur]);

    // Table contents carry no reset; only the valid bits are meaningful after reset.
    always_ff @(posedge clk) begin
        if (idle_like && tbl_we && !tbl_clr) begin
            tbl_reg_q[tbl_idx] <= tbl_reg;
            tbl_val_q[tbl_idx] <= tbl_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (idle_like) begin
            if (tbl_clr)
                valid <= '0;
            else if (tbl_we)
                valid[tbl_idx] <= 1'b1;
        end
    end

    // rf_raddr is loaded on entry to RD so read data is ready in the following CMP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            sof         <= 1'b0;
            checked     <= 1'b0;
            rf_raddr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_idx    <= '0;
            fail_actual <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_SETTLE;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_count   <= '0;
                        fail_idx    <= '0;
                        fail_actual <= '0;
                        sof         <= stop_on_fail;
                        cnt         <= (settle_override != '0) ? settle_override : SETTLE_C;
                        idx         <= '0;
                        checked     <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt <= CW'(1)) begin
                        state <= S_RD;
                        if (valid[0])
                            rf_raddr <= tbl_reg_q[0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RD: begin
                    if (idx == NCHK) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && checked;
                    end else if (valid[cur]) begin
                        state <= S_CMP;
                    end else begin
                        idx <= idx_inc;
                        if (!inc_end && valid[inc_lo])
                            rf_raddr <= tbl_reg_q[inc_lo];
                    end
                end
                S_CMP: begin
                    checked <= 1'b1;
                    if (mismatch) begin
                        if (err_count != ERR_MAX)
                            err_count <= err_count + 1'b1;
                        if (err_count == '0) begin
                            fail_idx    <= cur;
                            fail_actual <= rf_rdata;
                        end
                    end
                    if (mismatch && sof) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else begin
                        state <= S_RD;
                        idx   <= idx_inc;
                        if (!inc_end && valid[inc_lo])
                            rf_raddr <= tbl_reg_q[inc_lo];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
